// File: rtl/interrupt_arbiter.sv
// Interrupt arbiter: edge-captured flags, memory-mapped IE/IFG registers,
// fixed-priority vector generation with an acknowledge handshake FSM.
module interrupt_arbiter #(
    parameter logic [15:0] IE_ADDR  = 16'h0100,
    parameter logic [15:0] IFG_ADDR = 16'h0102,
    parameter logic [15:0] AUTOCLR  = 16'hFFFF
) (
    input  logic        MCLK,
    input  logic        reset,
    input  logic [15:0] IRQ,
    input  logic        NMIsrc,
    input  logic [15:0] MAB,
    input  logic [15:0] MDBin,
    input  logic        MW,
    input  logic        BW,
    input  logic        INTACK,
    output logic [15:0] MDBout,
    output logic        NMI,
    output logic        INT,
    output logic [5:0]  IntAddrLSBs
);

    typedef enum logic {IDLE, ACK} state_t;

    state_t      state_q, state_d;
    logic [15:0] ie_q, ie_d;
    logic [15:0] ifg_q, ifg_d;
    logic        nmiifg_q, nmiifg_d;
    logic [15:0] irq_q;
    logic        nmisrc_q;
    logic        nmi_q, int_q;
    logic [5:0]  vec_q, vec_d;

    logic        sel_ie, sel_ifg;
    logic        wr_lo, wr_hi;
    logic [15:0] wdata;
    logic [15:0] ie_w, ifg_w;
    logic [15:0] irq_set;
    logic [15:0] ifg_clr;
    logic        nmi_clr;
    logic [5:0]  winner;
    logic [5:0]  src_idx;

    assign sel_ie  = (MAB[15:1] == IE_ADDR[15:1]);
    assign sel_ifg = (MAB[15:1] == IFG_ADDR[15:1]);
    assign irq_set = IRQ & ~irq_q;

    always_comb begin
        MDBout = '0;
        if (sel_ie)
            MDBout = ie_q;
        else if (sel_ifg)
            MDBout = ifg_q;
    end

    // Byte writes replicate the low data byte onto both lanes; the lane enables pick the target.
    always_comb begin
        wr_lo = MW & (~BW | ~MAB[0]);
        wr_hi = MW & (~BW |  MAB[0]);
        wdata = BW ? {MDBin[7:0], MDBin[7:0]} : MDBin;
        ie_w  = ie_q;
        ifg_w = ifg_q;
        if (sel_ie) begin
            if (wr_lo) ie_w[7:0]  = wdata[7:0];
            if (wr_hi) ie_w[15:8] = wdata[15:8];
        end
        if (sel_ifg) begin
            if (wr_lo) ifg_w[7:0]  = wdata[7:0];
            if (wr_hi) ifg_w[15:8] = wdata[15:8];
        end
    end

    always_comb begin
        winner = 6'h3F;
        for (int unsigned k = 0; k < 16; k++) begin
            if (ie_q[k] && ifg_q[k])
                winner = 6'h2E + 6'(k);
        end
        if (nmiifg_q)
            winner = 6'h3E;
    end

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        ifg_clr = '0;
        nmi_clr = 1'b0;
        src_idx = vec_q - 6'h2E;
        case (state_q)
            IDLE: begin
                if (INTACK) begin
                    // Service the vector already presented; it stays frozen through ACK.
                    state_d = ACK;
                    if (vec_q == 6'h3E)
                        nmi_clr = 1'b1;
                    else if (vec_q >= 6'h2E && vec_q <= 6'h3D)
                        ifg_clr = AUTOCLR & (16'h0001 << src_idx[3:0]);
                end else begin
                    vec_d = winner;
                end
            end
            ACK: begin
                if (!INTACK)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        ie_d     = ie_w;
        ifg_d    = (ifg_w & ~ifg_clr) | irq_set;
        nmiifg_d = (nmiifg_q & ~nmi_clr) | (NMIsrc & ~nmisrc_q);
    end

    always_ff @(posedge MCLK) begin
        irq_q    <= IRQ;
        nmisrc_q <= NMIsrc;
        if (reset) begin
            state_q  <= IDLE;
            ie_q     <= '0;
            ifg_q    <= '0;
            nmiifg_q <= 1'b0;
            nmi_q    <= 1'b0;
            int_q    <= 1'b0;
            vec_q    <= 6'h3F;
        end else begin
            state_q  <= state_d;
            ie_q     <= ie_d;
            ifg_q    <= ifg_d;
            nmiifg_q <= nmiifg_d;
            nmi_q    <= nmiifg_q;
            int_q    <= |(ie_q & ifg_q);
            vec_q    <= vec_d;
        end
    end

    assign NMI         = nmi_q;
    assign INT         = int_q;
    assign IntAddrLSBs = vec_q;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Scoreboard bench: two arbiters (default AUTOCLR and AUTOCLR=0) share all inputs.
module tb_interrupt_arbiter;

    typedef enum int {MDB0, NMI0, INT0, VEC0, MDB1, VEC1} sig_t;
    typedef struct {
        sig_t        sel;
        logic [15:0] val;
        string       name;
    } exp_t;

    logic        MCLK = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] IRQ = '0;
    logic        NMIsrc = 1'b0;
    logic [15:0] MAB = '0;
    logic [15:0] MDBin = '0;
    logic        MW = 1'b0;
    logic        BW = 1'b0;
    logic        INTACK = 1'b0;

    logic [15:0] mdb0, mdb1;
    logic        nmi0, nmi1, int0, int1;
    logic [5:0]  vec0, vec1;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    always #5 MCLK = ~MCLK;

    interrupt_arbiter dut0 (
        .MCLK(MCLK), .reset(reset), .IRQ(IRQ), .NMIsrc(NMIsrc), .MAB(MAB),
        .MDBin(MDBin), .MW(MW), .BW(BW), .INTACK(INTACK), .MDBout(mdb0),
        .NMI(nmi0), .INT(int0), .IntAddrLSBs(vec0)
    );

    interrupt_arbiter #(.AUTOCLR(16'h0000)) dut1 (
        .MCLK(MCLK), .reset(reset), .IRQ(IRQ), .NMIsrc(NMIsrc), .MAB(MAB),
        .MDBin(MDBin), .MW(MW), .BW(BW), .INTACK(INTACK), .MDBout(mdb1),
        .NMI(nmi1), .INT(int1), .IntAddrLSBs(vec1)
    );

    function automatic logic [15:0] actual(input sig_t s);
        case (s)
            MDB0:    return mdb0;
            NMI0:    return {15'd0, nmi0};
            INT0:    return {15'd0, int0};
            VEC0:    return {10'd0, vec0};
            MDB1:    return mdb1;
            VEC1:    return {10'd0, vec1};
            default: return 16'hXXXX;
        endcase
    endfunction

    // Monitor: outputs are stable at the falling edge; drain every pending expectation there.
    always @(negedge MCLK) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [15:0] a;
            e = q.pop_front();
            a = actual(e.sel);
            tests++;
            if (a !== e.val) begin
                fails++;
                $display("FAIL %s: got %h expected %h at %0t", e.name, a, e.val, $time);
            end
        end
    end

    task automatic push(input sig_t s, input logic [15:0] v, input string n);
        exp_t e;
        e.sel = s; e.val = v; e.name = n;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge MCLK);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic b);
        MAB = a; MDBin = d; BW = b; MW = 1'b1;
        step();
        MW = 1'b0; BW = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state with IRQ[5] held high across release
        IRQ = 16'h0020;
        repeat (3) step();
        MAB = 16'h0100;
        push(VEC0, 16'h003F, "rst_vec");
        push(INT0, 16'h0000, "rst_int");
        push(NMI0, 16'h0000, "rst_nmi");
        push(MDB0, 16'h0000, "rst_ie");
        step();
        reset = 1'b0;
        wr(16'h0100, 16'hFFFF, 1'b0);
        step();
        MAB = 16'h0102;
        push(MDB0, 16'h0000, "held_irq_ifg");
        push(INT0, 16'h0000, "held_irq_int");
        push(VEC0, 16'h003F, "held_irq_vec");
        step();
        IRQ = '0;
        step();

        // Single source 3
        wr(16'h0100, 16'h0009, 1'b0);
        IRQ = 16'h0008; MAB = 16'h0102;
        step();
        push(MDB0, 16'h0008, "src3_ifg");
        push(INT0, 16'h0000, "src3_int_early");
        push(VEC0, 16'h003F, "src3_vec_early");
        IRQ = '0;
        step();
        push(INT0, 16'h0001, "src3_int");
        push(VEC0, 16'h0031, "src3_vec");
        wr(16'h0102, 16'h0000, 1'b0);
        step();
        push(INT0, 16'h0000, "clr_int");
        push(VEC0, 16'h003F, "clr_vec");

        // Sources 0 and 15 together, acknowledge 15
        wr(16'h0100, 16'hFFFF, 1'b0);
        IRQ = 16'h8001;
        step();
        IRQ = '0;
        step();
        push(VEC0, 16'h003D, "pri_vec15");
        push(INT0, 16'h0001, "pri_int");
        push(VEC1, 16'h003D, "pri_vec15_b");
        INTACK = 1'b1;
        step();
        INTACK = 1'b0; MAB = 16'h0102;
        push(MDB0, 16'h0001, "ack15_ifg");
        push(MDB1, 16'h8001, "ack15_ifg_noclr");
        push(VEC0, 16'h003D, "ack15_vec_frozen");
        step();
        push(VEC0, 16'h003D, "ack15_vec_exit");
        step();
        push(VEC0, 16'h002E, "ack15_vec_next");
        push(INT0, 16'h0001, "ack15_int");
        push(VEC1, 16'h003D, "ack15_vec_b");
        wr(16'h0102, 16'h0000, 1'b0);
        step();

        // NMI pre-empts pending source 15
        IRQ = 16'h8000;
        step();
        IRQ = '0;
        step();
        NMIsrc = 1'b1;
        step();
        step();
        push(NMI0, 16'h0001, "nmi_out");
        push(VEC0, 16'h003E, "nmi_vec");
        push(INT0, 16'h0001, "nmi_int");
        INTACK = 1'b1;
        step();
        INTACK = 1'b0;
        push(VEC0, 16'h003E, "nmi_ack_vec");
        push(NMI0, 16'h0001, "nmi_ack_out");
        step();
        push(NMI0, 16'h0000, "nmi_cleared");
        push(VEC0, 16'h003E, "nmi_exit_vec");
        step();
        push(VEC0, 16'h003D, "nmi_then_15");
        NMIsrc = 1'b0;
        wr(16'h0102, 16'h0000, 1'b0);
        step();

        // Long INTACK on source 2; AUTOCLR=0 keeps the flag
        IRQ = 16'h0004;
        step();
        IRQ = '0;
        step();
        push(VEC1, 16'h0030, "src2_vec_b");
        push(VEC0, 16'h0030, "src2_vec");
        INTACK = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            push(VEC1, 16'h0030, "ack_hold_vec_b");
            push(VEC0, 16'h0030, "ack_hold_vec");
        end
        MAB = 16'h0102;
        push(MDB1, 16'h0004, "noclr_ifg");
        push(MDB0, 16'h0000, "autoclr_ifg");
        step();
        INTACK = 1'b0;
        step();
        step();
        push(VEC1, 16'h0030, "noclr_vec_after");
        push(VEC0, 16'h003F, "autoclr_vec_after");
        wr(16'h0102, 16'h0000, 1'b0);
        step();

        // Set wins on the clearing edge; new edge during ACK
        IRQ = 16'h0010;
        step();
        IRQ = '0;
        step();
        INTACK = 1'b1; IRQ = 16'h0010;
        step();
        IRQ = 16'h0002;
        step();
        MAB = 16'h0102;
        push(MDB0, 16'h0012, "setwins_ifg");
        push(VEC0, 16'h0032, "setwins_vec");
        INTACK = 1'b0; IRQ = '0;
        step();
        step();
        push(VEC0, 16'h0032, "setwins_vec_after");
        push(INT0, 16'h0001, "setwins_int");
        wr(16'h0102, 16'h0000, 1'b0);
        step();

        // Byte writes and read decode
        wr(16'h0100, 16'h1234, 1'b0);
        wr(16'h0101, 16'h00A5, 1'b1);
        MAB = 16'h0100;
        push(MDB0, 16'hA534, "byte_hi");
        step();
        wr(16'h0100, 16'h00C3, 1'b1);
        MAB = 16'h0100;
        push(MDB0, 16'hA5C3, "byte_lo");
        step();
        wr(16'h0102, 16'h5A5A, 1'b0);
        MAB = 16'h0102;
        push(MDB0, 16'h5A5A, "ifg_read");
        step();
        MAB = 16'h0200;
        push(MDB0, 16'h0000, "unmapped_read");
        step();
        MDBin = 16'hFFFF; MW = 1'b1;
        push(MDB0, 16'h0000, "unmapped_read_mw");
        step();
        MW = 1'b0; MAB = 16'h0100;
        push(MDB0, 16'hA5C3, "unmapped_write_ignored");
        step();
        MAB = 16'h0102; MDBin = 16'h0000; MW = 1'b1; IRQ = 16'h0080;
        step();
        MW = 1'b0; IRQ = '0;
        push(MDB0, 16'h0080, "write_vs_set");
        step();

        // Reset during ACK (NMI source, IE all zero)
        wr(16'h0100, 16'h0000, 1'b0);
        wr(16'h0102, 16'h0000, 1'b0);
        step();
        NMIsrc = 1'b1;
        step();
        step();
        push(VEC0, 16'h003E, "nmi_noie_vec");
        push(NMI0, 16'h0001, "nmi_noie_out");
        INTACK = 1'b1;
        step();
        reset = 1'b1;
        step();
        push(VEC0, 16'h003F, "rst_ack_vec");
        push(NMI0, 16'h0000, "rst_ack_nmi");
        push(INT0, 16'h0000, "rst_ack_int");
        push(VEC1, 16'h003F, "rst_ack_vec_b");
        reset = 1'b0; INTACK = 1'b0;
        step();
        step();
        MAB = 16'h0102;
        push(VEC0, 16'h003F, "post_rst_vec");
        push(NMI0, 16'h0000, "post_rst_nmi");
        push(MDB0, 16'h0000, "post_rst_ifg");
        step();

        repeat (3) step();
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations pending, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/interrupt_arbiter.md
INTERRUPT_ARBITER -- requirements
Module: interrupt_arbiter

Interface
REQ-001 Parameter IE_ADDR, 16'h0100, word address of the interrupt-enable register.
REQ-002 Parameter IFG_ADDR, 16'h0102, word address of the interrupt-flag register.
REQ-003 Parameter AUTOCLR, 16'hFFFF, per-source mask; 1 = flag auto-cleared on vector acknowledge.
REQ-004 MCLK  in  1  master clock; all state changes on posedge MCLK.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 IRQ  in  16  peripheral request lines, bit 15 = highest maskable priority.
REQ-007 NMIsrc  in  1  non-maskable request pin.
REQ-008 MAB  in  16  memory address bus from CPU.
REQ-009 MDBin  in  16  write data from CPU (CPU MDBout).
REQ-010 MW  in  1  memory write strobe.
REQ-011 BW  in  1  byte/word select (1 = byte).
REQ-012 INTACK  in  1  CPU interrupt acknowledge.
REQ-013 MDBout  out  16  register read data to CPU.
REQ-014 NMI  out  1  non-maskable request to CPU.
REQ-015 INT  out  1  maskable request to CPU.
REQ-016 IntAddrLSBs  out  6  vector address bits [6:1] to CPU.

Function
REQ-017 IRQ is sampled into IRQ_q each cycle; IFG[k] sets on the edge where IRQ[k]=1 and IRQ_q[k]=0 (rising-edge capture).
REQ-018 NMIIFG sets on the rising edge of NMIsrc, detected the same way via NMI_q.
REQ-019 Word write (MW=1, BW=0) with MAB[15:1] matching IE_ADDR or IFG_ADDR loads MDBin into that register.
REQ-020 Byte write (MW=1, BW=1) loads MDBin[7:0] into the low byte when MAB[0]=0, or into the high byte when MAB[0]=1; the other byte is unchanged.
REQ-021 Same-cycle hardware edge and software write to IFG: the written value applies, then hardware-set bits are ORed in (set wins).
REQ-022 MDBout is combinational: IE or IFG when MAB[15:1] matches; 16'h0000 otherwise, regardless of MW.
REQ-023 NMI (registered) equals NMIIFG delayed one cycle; INT (registered) equals |(IE & IFG) delayed one cycle.
REQ-024 In IDLE, IntAddrLSBs registers the winner each cycle: 6'h3E if NMIIFG; else 6'h2E + k for highest k with IE[k]&IFG[k]; else 6'h3F.
REQ-025 FSM states: IDLE, ACK.
REQ-026 IDLE -> ACK on the first cycle INTACK=1; at that edge the current IntAddrLSBs source is latched as the serviced source.
REQ-027 On IDLE -> ACK: a serviced NMI clears NMIIFG; serviced source k clears IFG[k] only when AUTOCLR[k]=1; a serviced value of 6'h3F clears nothing.
REQ-028 In ACK, IntAddrLSBs is frozen and no further clears occur, however long INTACK stays high.
REQ-029 ACK -> IDLE on the first cycle INTACK=0; the vector resumes tracking on the next edge.
REQ-030 A new edge arriving during ACK sets its flag normally; a hardware set on the clearing edge of the same bit wins (flag stays 1).
REQ-031 NMI has priority over all maskable sources, independent of IE.

Reset
REQ-032 While reset=1: IE=0, IFG=0, NMIIFG=0, FSM=IDLE, INT=0, NMI=0, IntAddrLSBs=6'h3F.
REQ-033 While reset=1: IRQ_q<=IRQ and NMI_q<=NMIsrc, so levels held high across reset release produce no edge.
REQ-034 Reset asserted during ACK returns the FSM to IDLE; pending clears are discarded.

Verification
REQ-035 Write IE=16'h0009, pulse IRQ[3] -> IFG=16'h0008 one edge later; INT=1 and IntAddrLSBs=6'h31 one edge after that.
REQ-036 IE=16'hFFFF, IRQ[0] and IRQ[15] rise together -> IntAddrLSBs=6'h3D; INTACK pulse -> IFG=16'h0001, then IntAddrLSBs=6'h2E.
REQ-037 NMIsrc rising edge while IRQ[15] pending and enabled -> NMI=1 and IntAddrLSBs=6'h3E; INTACK -> NMIIFG=0, vector becomes 6'h3D.
REQ-038 AUTOCLR=16'h0000, INTACK held 5 cycles on source 2 -> IFG[2] stays 1, IntAddrLSBs fixed at 6'h30 throughout ACK.
REQ-039 Byte write MAB=IE_ADDR+1, MDBin=16'h00A5 onto IE=16'h1234 -> IE=16'hA534; read at IFG_ADDR returns IFG; read at 16'h0200 returns 16'h0000.
REQ-040 IRQ held high through reset release -> IFG stays 16'h0000, INT=0; reset asserted mid-ACK -> all outputs at reset values next edge.
